// File: rtl/intr_ccr_sequencer.sv
// Interrupt entry/return sequencer driving the CCR save/restore interface,
// the return-PC stack accesses and the ISR vector fetch. One interrupt level;
// a further request is held pending until the active ISR returns.
module intr_ccr_sequencer #(
  parameter int unsigned             DATA_W      = 8,
  parameter logic [DATA_W-1:0]       VECTOR_ADDR = DATA_W'(1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INTR,
  input  logic              RTI_Decoded,
  input  logic              Pipe_Empty,
  input  logic [DATA_W-1:0] PC_Current,
  input  logic [DATA_W-1:0] SP_Current,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic              Stall,
  output logic              Flush,
  output logic              CCR_Hold,
  output logic              CCR_Shift_Left,
  output logic              CCR_Shift_Right,
  output logic              SP_Dec,
  output logic              SP_Inc,
  output logic              Mem_We,
  output logic              Mem_Re,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  output logic              PC_Load,
  output logic [DATA_W-1:0] PC_Load_Value,
  output logic              Int_Active
);

  typedef enum logic [3:0] {
    S_IDLE, S_DRAIN, S_SAVE, S_VRD, S_VLD,
    S_RDRAIN, S_POP, S_RRD, S_RLD
  } state_e;

  state_e state_q, state_d;
  logic   intr_q;
  logic   pending_q, pending_d;
  logic   int_active_q, int_active_d;
  logic   req_c;
  logic   save_entry_c;

  logic   stall_q, flush_q, shl_q, shr_q, sp_dec_q, sp_inc_q;
  logic   mem_we_q, mem_re_q, pc_load_q;

  assign req_c = INTR & ~intr_q;

  // Next state, pending request latch and interrupt-active flag
  always_comb begin
    state_d      = state_q;
    int_active_d = int_active_q;
    save_entry_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (int_active_q && RTI_Decoded) begin
          state_d = S_RDRAIN;
        end else if ((req_c || pending_q) && !int_active_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (Pipe_Empty) begin
          state_d      = S_SAVE;
          save_entry_c = 1'b1;
        end
      end
      S_SAVE:   state_d = S_VRD;
      S_VRD:    state_d = S_VLD;
      S_VLD: begin
        state_d      = S_IDLE;
        int_active_d = 1'b1;
      end
      S_RDRAIN: begin
        if (Pipe_Empty) state_d = S_POP;
      end
      S_POP:    state_d = S_RRD;
      S_RRD:    state_d = S_RLD;
      S_RLD: begin
        state_d      = S_IDLE;
        int_active_d = 1'b0;
      end
      default:  state_d = S_IDLE;
    endcase
    // A request arriving while the current one enters SAVE must survive
    pending_d = (pending_q & ~save_entry_c) | req_c;
  end

  // State, request tracking and control strobes registered from the next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      intr_q       <= 1'b0;
      pending_q    <= 1'b0;
      int_active_q <= 1'b0;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      shl_q        <= 1'b0;
      shr_q        <= 1'b0;
      sp_dec_q     <= 1'b0;
      sp_inc_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      pc_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      intr_q       <= INTR;
      pending_q    <= pending_d;
      int_active_q <= int_active_d;
      stall_q      <= (state_d != S_IDLE);
      flush_q      <= (state_d == S_VLD) || (state_d == S_RLD);
      shl_q        <= (state_d == S_SAVE);
      shr_q        <= (state_d == S_RLD);
      sp_dec_q     <= (state_d == S_SAVE);
      sp_inc_q     <= (state_d == S_POP);
      mem_we_q     <= (state_d == S_SAVE);
      mem_re_q     <= (state_d == S_VRD) || (state_d == S_RRD);
      pc_load_q    <= (state_d == S_VLD) || (state_d == S_RLD);
    end
  end

  // Address/data paths follow live SP, PC and read data within the owning state
  always_comb begin
    Mem_Addr      = '0;
    Mem_Wdata     = '0;
    PC_Load_Value = '0;
    case (state_q)
      S_SAVE: begin
        Mem_Addr  = SP_Current;
        Mem_Wdata = PC_Current;
      end
      S_VRD:        Mem_Addr      = VECTOR_ADDR;
      S_RRD:        Mem_Addr      = SP_Current;
      S_VLD, S_RLD: PC_Load_Value = Mem_Rdata;
      default: ;
    endcase
  end

  assign Stall           = stall_q;
  assign CCR_Hold        = stall_q;
  assign Flush           = flush_q;
  assign CCR_Shift_Left  = shl_q;
  assign CCR_Shift_Right = shr_q;
  assign SP_Dec          = sp_dec_q;
  assign SP_Inc          = sp_inc_q;
  assign Mem_We          = mem_we_q;
  assign Mem_Re          = mem_re_q;
  assign PC_Load         = pc_load_q;
  assign Int_Active      = int_active_q;

endmodule

// File: tb/tb_intr_ccr_sequencer.sv
// Bench for intr_ccr_sequencer: directed scenarios followed by random traffic,
// compared cycle by cycle against a transaction-level model with a stack/memory environment.
module tb_intr_ccr_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INTR = 1'b0;
  logic       RTI_Decoded = 1'b0;
  logic       Pipe_Empty = 1'b1;
  logic [7:0] PC_Current = 8'h00;
  logic [7:0] SP_Current = 8'hFF;
  logic [7:0] Mem_Rdata = 8'h00;
  logic       Stall, Flush, CCR_Hold, CCR_Shift_Left, CCR_Shift_Right;
  logic       SP_Dec, SP_Inc, Mem_We, Mem_Re, PC_Load, Int_Active;
  logic [7:0] Mem_Addr, Mem_Wdata, PC_Load_Value;

  always #5 CLK = ~CLK;

  intr_ccr_sequencer dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .RTI_Decoded(RTI_Decoded),
    .Pipe_Empty(Pipe_Empty), .PC_Current(PC_Current), .SP_Current(SP_Current),
    .Mem_Rdata(Mem_Rdata), .Stall(Stall), .Flush(Flush), .CCR_Hold(CCR_Hold),
    .CCR_Shift_Left(CCR_Shift_Left), .CCR_Shift_Right(CCR_Shift_Right),
    .SP_Dec(SP_Dec), .SP_Inc(SP_Inc), .Mem_We(Mem_We), .Mem_Re(Mem_Re),
    .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata), .PC_Load(PC_Load),
    .PC_Load_Value(PC_Load_Value), .Int_Active(Int_Active)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: kind 0=none, 1=entry, 2=return; step 0=waiting for drain, 1..3 = fixed phases
  int   m_kind = 0;
  int   m_step = 0;
  bit   m_active = 1'b0;
  bit   m_pend = 1'b0;
  bit   m_intr_prev = 1'b0;

  // Environment: memory, SP register, saved-PC stack, read-data pipeline
  logic [7:0] mem [256];
  logic [7:0] stk [$];
  logic [7:0] env_sp = 8'hFF;
  logic [7:0] isr_vec;
  logic [7:0] rd_data = 8'h00;
  bit         rd_valid = 1'b0;

  // Next-cycle stimulus chosen by the test sequence
  bit         nx_intr = 1'b0, nx_rti = 1'b0, nx_pe = 1'b1, nx_rst = 1'b1;
  logic [7:0] nx_pc = 8'h00;

  // Expected outputs for the current cycle
  bit         e_stall, e_flush, e_shl, e_shr, e_spdec, e_spinc, e_we, e_re, e_pcl;
  logic [7:0] e_addr, e_wdata, e_pcv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic compute_exp();
    bit ent, ret;
    ent     = (m_kind == 1);
    ret     = (m_kind == 2);
    e_stall = (m_kind != 0);
    e_flush = (m_kind != 0) && (m_step == 3);
    e_pcl   = e_flush;
    e_shl   = ent && (m_step == 1);
    e_we    = e_shl;
    e_spdec = e_shl;
    e_spinc = ret && (m_step == 1);
    e_shr   = ret && (m_step == 3);
    e_re    = (m_kind != 0) && (m_step == 2);
    e_addr  = 8'h00;
    e_wdata = 8'h00;
    e_pcv   = 8'h00;
    if (ent && m_step == 1) begin
      e_addr  = SP_Current;
      e_wdata = PC_Current;
    end
    if (ent && m_step == 2) e_addr = 8'h01;
    if (ret && m_step == 2) e_addr = SP_Current;
    if (ent && m_step == 3) e_pcv = isr_vec;
    if (ret && m_step == 3) e_pcv = (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_ctl"},
             {21'd0, Stall, Flush, CCR_Hold, CCR_Shift_Left, CCR_Shift_Right,
              SP_Dec, SP_Inc, Mem_We, Mem_Re, PC_Load, Int_Active},
             {21'd0, e_stall, e_flush, e_stall, e_shl, e_shr,
              e_spdec, e_spinc, e_we, e_re, e_pcl, m_active});
    check_eq({tag, "_addr"},  32'(Mem_Addr),      32'(e_addr));
    check_eq({tag, "_wdata"}, 32'(Mem_Wdata),     32'(e_wdata));
    check_eq({tag, "_pcval"}, 32'(PC_Load_Value), 32'(e_pcv));
  endtask

  task automatic model_reset();
    m_kind      = 0;
    m_step      = 0;
    m_active    = 1'b0;
    m_pend      = 1'b0;
    m_intr_prev = 1'b0;
    rd_valid    = 1'b0;
    stk.delete();
  endtask

  // Advance the model across one active edge using the inputs held at that edge
  task automatic model_edge();
    bit req, clr;
    compute_exp();
    req         = INTR && !m_intr_prev;
    m_intr_prev = INTR;
    clr         = 1'b0;
    rd_valid    = 1'b0;
    if (e_we) begin
      mem[e_addr] = e_wdata;
      stk.push_back(e_wdata);
    end
    if (e_re) begin
      rd_valid = 1'b1;
      rd_data  = mem[e_addr];
    end
    if (e_spdec) env_sp = env_sp - 8'd1;
    if (e_spinc) env_sp = env_sp + 8'd1;
    if (e_shr && stk.size() > 0) void'(stk.pop_back());
    if (m_kind == 0) begin
      if (m_active && RTI_Decoded) begin
        m_kind = 2; m_step = 0;
      end else if ((req || m_pend) && !m_active) begin
        m_kind = 1; m_step = 0;
      end
    end else if (m_step == 0) begin
      if (Pipe_Empty) begin
        m_step = 1;
        clr    = (m_kind == 1);
      end
    end else if (m_step < 3) begin
      m_step++;
    end else begin
      m_active = (m_kind == 1);
      m_kind   = 0;
      m_step   = 0;
    end
    m_pend = (m_pend && !clr) || req;
  endtask

  // One clock: model update at the edge, new inputs shortly after, check mid-cycle
  task automatic cycle();
    @(posedge CLK);
    if (!RST) model_edge();
    #1;
    RST = nx_rst;
    if (nx_rst) model_reset();
    INTR        = nx_intr;
    RTI_Decoded = nx_rti;
    Pipe_Empty  = nx_pe;
    PC_Current  = nx_pc;
    SP_Current  = env_sp;
    Mem_Rdata   = rd_valid ? rd_data : 8'($urandom);
    @(negedge CLK);
    compute_exp();
    check_all("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    isr_vec = 8'h40;
    mem[1]  = isr_vec;
    model_reset();

    // Reset values
    run(2);
    nx_rst = 1'b0;
    nx_pc  = 8'h20;
    run(2);

    // Entry with an empty pipe
    nx_intr = 1'b1;
    run(7);

    // Return from interrupt
    nx_rti = 1'b1; run(1);
    nx_rti = 1'b0; run(7);

    // Entry held off by a busy pipe, then return
    nx_intr = 1'b0; run(1);
    nx_intr = 1'b1; nx_pe = 1'b0; nx_pc = 8'h33; run(4);
    nx_pe = 1'b1; run(5);
    nx_rti = 1'b1; run(1);
    nx_rti = 1'b0; run(6);

    // Second request during an active ISR, serviced after the return
    nx_intr = 1'b0; run(1);
    nx_intr = 1'b1; run(6);
    nx_intr = 1'b0; run(1);
    nx_intr = 1'b1; nx_pc = 8'h5A; run(1);
    nx_intr = 1'b0; run(1);
    nx_intr = 1'b1; nx_rti = 1'b1; run(1);
    nx_rti = 1'b0; run(14);
    nx_rti = 1'b1; run(1);
    nx_rti = 1'b0; run(7);

    // Stray return with no ISR active
    nx_rti = 1'b1; run(1);
    nx_rti = 1'b0; run(3);

    // Reset while fetching the vector
    nx_intr = 1'b0; run(1);
    nx_intr = 1'b1;
    begin
      int guard;
      guard = 0;
      while (!(m_kind == 1 && m_step == 2) && guard < 20) begin
        cycle();
        guard++;
      end
      check_eq("reach_vrd", 32'(guard < 20), 32'd1);
    end
    RST    = 1'b1;
    nx_rst = 1'b1;
    #1;
    model_reset();
    compute_exp();
    check_all("rst_async");
    run(2);
    nx_rst = 1'b0;
    run(8);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) nx_intr = ~nx_intr;
      nx_rti = ($urandom_range(0, 5) == 0);
      nx_pe  = ($urandom_range(0, 3) != 0);
      nx_pc  = 8'($urandom);
      nx_rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    nx_rst = 1'b0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
